// File: rtl/fsm_gen_pkg.sv
// Shared FSM state encoding and default sizing for the serial pattern transmitter.
// Imported by the top, its run tracker and the handshake interface.
package fsm_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_RUN   = 4;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Request/serial-output bundle of serial_pattern_tx.
// master drives a frame request, slave is the transmitter side.
interface serial_pattern_tx_if
  import fsm_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                   start;
  logic [WIDTH-1:0]       pattern;
  logic [$clog2(WIDTH):0] len;
  logic                   w;
  logic                   w_valid;
  logic                   busy;
  logic                   done;
  logic                   z_exp;

  modport master (
    output start, pattern, len,
    input  w, w_valid, busy, done, z_exp
  );

  modport slave (
    input  start, pattern, len,
    output w, w_valid, busy, done, z_exp
  );

endinterface

// File: rtl/run_tracker.sv
// Tracks runs of identical emitted bits; z is registered and rises
// the cycle after a bit that makes the run reach RUN.
module run_tracker
  import fsm_gen_pkg::*;
#(
  parameter int RUN = DEF_RUN
) (
  input  logic clk,
  input  logic aclr,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_valid,
  output logic z
);

  localparam int CW = $clog2(RUN + 1);
  typedef logic [CW-1:0] cnt_t;

  cnt_t cnt_q, cnt_d;
  logic last_q, last_d;
  logic z_q, z_d;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    z_d    = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (bit_valid) begin
      last_d = bit_in;
      // a zero count marks the first bit of a frame
      if (cnt_q == '0 || bit_in != last_q) begin
        cnt_d = cnt_t'(1);
      end else if (cnt_q < cnt_t'(RUN)) begin
        cnt_d = cnt_q + 1'b1;
      end
      z_d = (cnt_d >= cnt_t'(RUN));
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      z_q    <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// LSB-first serial pattern transmitter (IDLE/SHIFT/DONE), registered outputs.
// Define SERIAL_PATTERN_TX_EXPECT_EN to build the run tracker driving z_exp.
module serial_pattern_tx
  import fsm_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RUN   = DEF_RUN
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   start,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [$clog2(WIDTH):0] len,
  output logic                   w,
  output logic                   w_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   z_exp
);

  localparam int LW = $clog2(WIDTH) + 1;
  typedef logic [LW-1:0] idx_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  idx_t             len_q, len_d;
  idx_t             idx_q, idx_d;
  logic             w_q, w_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  idx_t             len_eff;

  assign len_eff = (len > idx_t'(WIDTH)) ? idx_t'(WIDTH) : len;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    w_d     = 1'b0;
    v_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d  = pattern;
          len_d  = len_eff;
          busy_d = 1'b1;
          if (len_eff == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // first bit goes out the cycle right after acceptance
            state_d = SHIFT;
            w_d     = pattern[0];
            v_d     = 1'b1;
            idx_d   = idx_t'(1);
          end
        end
      end
      SHIFT: begin
        if (idx_q == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          w_d   = pat_q[idx_q[LW-2:0]];
          v_d   = 1'b1;
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      w_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w       = w_q;
  assign w_valid = v_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef SERIAL_PATTERN_TX_EXPECT_EN
  logic accept;

  assign accept = (state_q == IDLE) && start;

  run_tracker #(
    .RUN (RUN)
  ) u_run (
    .clk       (clk),
    .aclr      (aclr),
    .clear     (accept),
    .bit_in    (w_q),
    .bit_valid (v_q),
    .z         (z_exp)
  );
`else
  assign z_exp = 1'b0;
`endif

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter: WIDTH, 16, maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter: RUN, 4, number of identical consecutive bits that counts as a detected run.
REQ-003 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: aclr  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request to transmit; sampled only in IDLE.
REQ-006 SHALL have port: pattern  input  WIDTH  bits to send, LSB first; captured on accepted start.
REQ-007 SHALL have port: len  input  clog2(WIDTH)+1  number of bits to send; captured on accepted start.
REQ-008 SHALL have port: w  output  1  serial data bit.
REQ-009 SHALL have port: w_valid  output  1  w carries a pattern bit this cycle.
REQ-010 SHALL have port: busy  output  1  transmission in progress.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: z_exp  output  1  expected run-detector output (REQ-031).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL, in IDLE with start=1 at edge t, capture pattern and len and enter SHIFT at t+1.
REQ-015 SHALL treat len > WIDTH as WIDTH.
REQ-016 SHALL, for len=0, go IDLE -> DONE directly; no bit emitted, w_valid stays 0.
REQ-017 SHALL, in SHIFT, drive w = pattern[k] and w_valid=1 in cycle t+1+k, for k = 0..len-1.
REQ-018 SHALL, after the last bit, enter DONE for exactly one cycle, then IDLE.
REQ-019 SHALL assert busy=1 in SHIFT and DONE, and 0 in IDLE.
REQ-020 SHALL assert done=1 only in DONE.
REQ-021 SHALL drive w=0 whenever w_valid=0.
REQ-022 SHALL ignore start while busy; captured pattern and len stay unchanged.
REQ-023 SHALL accept a start in the IDLE cycle right after DONE, giving back-to-back frames with one idle gap cycle.
REQ-024 SHALL hold the bit index in clog2(WIDTH)+1 bits, with no wrap-around at len=WIDTH.

Reset
REQ-025 SHALL, with aclr=1 at an edge, enter IDLE.
REQ-026 SHALL clear w, w_valid, busy, done, z_exp, bit index and run counter to 0 on reset.
REQ-027 SHALL abort any frame in progress on reset mid-frame, with no done pulse.
REQ-028 SHALL give aclr priority over start in the same cycle.

Configuration
REQ-029 SHALL compile in the expected-output model only when macro SERIAL_PATTERN_TX_EXPECT_EN is defined.
REQ-030 SHALL, without SERIAL_PATTERN_TX_EXPECT_EN, tie z_exp to constant 0 and omit the run tracker.
REQ-031 SHALL, with the macro defined, compute z_exp as follows:
- keep the last emitted bit and a run count saturating at RUN;
- clear the run count on accepted start;
- first bit of a frame sets count=1; a same-valued bit increments it; a different bit resets it to 1;
- register z_exp: z_exp=1 in the cycle after a bit is emitted with count (after update) >= RUN, else 0;
- force z_exp=0 in IDLE except that trailing cycle.

Structure
REQ-032 SHALL take the state enumeration (IDLE, SHIFT, DONE) and the default WIDTH and RUN constants from shared package fsm_gen_pkg.
REQ-033 SHALL place the run-count/z_exp logic in sub-module run_tracker (inputs: clk, aclr, clear, bit, bit_valid; output: z); instantiate it only under the macro.

Verification
REQ-034 SHALL cover: pattern=16'h00F0, len=8, start at t -> w over t+1..t+8 = 0,0,0,0,1,1,1,1; done at t+9; with macro, z_exp=1 at t+5 and t+9 only.
REQ-035 SHALL cover: pattern=16'hAAAA, len=16 -> 16 alternating bits starting with 0; z_exp never 1; done at t+17.
REQ-036 SHALL cover: len=0 -> done at t+1; w_valid never 1.
REQ-037 SHALL cover: len=20 with WIDTH=16 -> exactly 16 bits emitted; pattern[15] at t+16.
REQ-038 SHALL cover: start pulsed at t+3 during a frame -> ignored, output unchanged.
REQ-039 SHALL cover: aclr=1 at t+4 mid-frame -> IDLE next cycle, all outputs 0, no done pulse.
